// File: rtl/agc_error_tracker.sv
// Registered AGC error stage: saturated R-|z| error with deadband, 1-cycle latency,
// and a lock-detect FSM. Define AGC_ERR_SMOOTH_EN to add the error_avg smoothing output.
module agc_error_tracker #(
    parameter int DATA_W     = 16,
    parameter int FRAC_W     = 8,
    parameter int DEADBAND   = 16,
    parameter int LOCK_CNT   = 32,
    parameter int UNLOCK_CNT = 4
`ifdef AGC_ERR_SMOOTH_EN
    ,
    parameter int SMOOTH_SHIFT = 3
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] target_R,
    input  logic [DATA_W-1:0] current_mag,
    output logic              out_valid,
    output logic [DATA_W-1:0] error,
    output logic              in_band,
    output logic              sat,
`ifdef AGC_ERR_SMOOTH_EN
    output logic [DATA_W-1:0] error_avg,
`endif
    output logic              locked
);

    localparam int CNT_MAX = (LOCK_CNT > UNLOCK_CNT) ? LOCK_CNT : UNLOCK_CNT;
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;
    localparam logic [CNT_W-1:0]  LOCK_T   = CNT_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0]  UNLOCK_T = CNT_W'(UNLOCK_CNT);
    localparam logic [DATA_W:0]   DB_T     = (DATA_W + 1)'(DEADBAND);

    if (FRAC_W < 0 || FRAC_W >= DATA_W || LOCK_CNT < 1 || UNLOCK_CNT < 1 || DEADBAND < 0)
    begin : g_param_check
        $error("agc_error_tracker: invalid parameter set");
    end

    typedef enum logic [1:0] {ACQUIRE, SETTLE, LOCKED} state_t;

    // A DATA_W+1 value fits DATA_W bits only when its top two bits agree.
    function automatic logic [DATA_W-1:0] clamp(input logic [DATA_W:0] v);
        if (v[DATA_W] != v[DATA_W-1])
            return {v[DATA_W], {(DATA_W-1){~v[DATA_W]}}};
        return v[DATA_W-1:0];
    endfunction

    logic [DATA_W:0]   diff;
    logic              sat_next;
    logic [DATA_W-1:0] e_sat;
    logic [DATA_W:0]   e_ext;
    logic [DATA_W:0]   e_mag;
    logic              in_band_next;
    logic [DATA_W-1:0] error_next;

    assign diff         = {target_R[DATA_W-1], target_R} - {current_mag[DATA_W-1], current_mag};
    assign sat_next     = diff[DATA_W] ^ diff[DATA_W-1];
    assign e_sat        = clamp(diff);
    assign e_ext        = {e_sat[DATA_W-1], e_sat};
    assign e_mag        = e_ext[DATA_W] ? -e_ext : e_ext;
    // A clamped sample never qualifies as in-band, however wide the deadband.
    assign in_band_next = !sat_next && (e_mag <= DB_T);
    assign error_next   = in_band_next ? '0 : e_sat;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_reg + CNT_W'(1);

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            ACQUIRE: begin
                if (in_band_next) begin
                    if (LOCK_CNT == 1) begin
                        state_next = LOCKED;
                        cnt_next   = '0;
                    end else begin
                        state_next = SETTLE;
                        cnt_next   = CNT_W'(1);
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            SETTLE: begin
                if (in_band_next) begin
                    if (cnt_inc == LOCK_T) begin
                        state_next = LOCKED;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end else begin
                    state_next = ACQUIRE;
                    cnt_next   = '0;
                end
            end
            LOCKED: begin
                if (!in_band_next) begin
                    if (cnt_inc == UNLOCK_T) begin
                        state_next = ACQUIRE;
                        cnt_next   = '0;
                    end else begin
                        cnt_next = cnt_inc;
                    end
                end else begin
                    cnt_next = '0;
                end
            end
            default: begin
                state_next = ACQUIRE;
                cnt_next   = '0;
            end
        endcase
    end

    logic              out_valid_reg;
    logic [DATA_W-1:0] error_reg;
    logic              in_band_reg;
    logic              sat_reg;
    logic              locked_reg;

`ifdef AGC_ERR_SMOOTH_EN
    logic [DATA_W-1:0]        avg_reg;
    logic [DATA_W-1:0]        avg_next;
    logic signed [DATA_W:0]   avg_delta;
    logic signed [DATA_W:0]   avg_step;
    logic [DATA_W:0]          avg_sum;

    assign avg_delta = $signed({error_next[DATA_W-1], error_next}) - $signed({avg_reg[DATA_W-1], avg_reg});
    assign avg_step  = avg_delta >>> SMOOTH_SHIFT;
    assign avg_sum   = {avg_reg[DATA_W-1], avg_reg} + avg_step;
    assign avg_next  = clamp(avg_sum);
    assign error_avg = avg_reg;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            error_reg     <= '0;
            in_band_reg   <= 1'b0;
            sat_reg       <= 1'b0;
            locked_reg    <= 1'b0;
            state_reg     <= ACQUIRE;
            cnt_reg       <= '0;
`ifdef AGC_ERR_SMOOTH_EN
            avg_reg       <= '0;
`endif
        end else begin
            out_valid_reg <= in_valid;
            if (in_valid) begin
                error_reg   <= error_next;
                in_band_reg <= in_band_next;
                sat_reg     <= sat_next;
                state_reg   <= state_next;
                cnt_reg     <= cnt_next;
                locked_reg  <= (state_next == LOCKED);
`ifdef AGC_ERR_SMOOTH_EN
                avg_reg     <= avg_next;
`endif
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign error     = error_reg;
    assign in_band   = in_band_reg;
    assign sat       = sat_reg;
    assign locked    = locked_reg;

endmodule
